bist_controller: RTL
====================

// Module: bist_controller
// PURPOSE
//  Sequences one BIST session around the 3-bit LFSR pattern generator (TPG), the circuit under
//  test (CUT) and a MISR output response analyser (ORA). Re-initialises the TPG and clears the
//  ORA, steps PATTERN_COUNT patterns, flushes CUT latency, then compares the signature with a
//  golden value. Sits between the system test port (start/abort/done/pass) and the BIST datapath.
// PARAMETERS
//  PATTERN_COUNT  7       patterns applied per session (1..255); 7 = full 3-bit LFSR period
//  CUT_LATENCY    0       CUT pipeline depth in cycles (0..15); ORA keeps capturing this long after the TPG stops
//  SIG_WIDTH      3       ORA signature width
//  GOLDEN_SIG     3'b101  expected fault-free signature, SIG_WIDTH bits
// PORTS
//  clock       in   1          rising-edge clock
//  reset       in   1          asynchronous, active-low reset (0 = reset)
//  start       in   1          session request; acted on only in IDLE or DONE
//  abort       in   1          cancel the session in progress
//  signature   in   SIG_WIDTH  current ORA contents
//  tpg_init    out  1          active-high init to the LFSR (loads its seed)
//  tpg_en      out  1          LFSR advance enable / pattern valid
//  test_mode   out  1          1 = CUT inputs muxed from the TPG
//  ora_clear   out  1          synchronous clear of the ORA
//  ora_en      out  1          ORA capture enable
//  busy        out  1          session in progress (INIT..COMPARE)
//  done        out  1          result valid (DONE state)
//  pass        out  1          1 = signature matched GOLDEN_SIG; meaningful only while done=1
//  sig_out     out  SIG_WIDTH  signature latched in COMPARE
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE, counter=0, all outputs 0, sig_out=0.
//  - FSM states: IDLE, INIT, RUN, FLUSH, COMPARE, DONE. All outputs are registered/Moore, decoded from state only.
//  - IDLE: all outputs 0. If start=1 -> INIT.
//  - INIT (1 cycle): tpg_init=1, ora_clear=1, test_mode=1, busy=1. Load counter = PATTERN_COUNT-1. -> RUN.
//  - RUN: tpg_en=1, ora_en=1, test_mode=1, busy=1. Decrement counter each cycle; exactly
//    PATTERN_COUNT RUN cycles. At counter==0: -> FLUSH if CUT_LATENCY>0 (load counter=CUT_LATENCY-1),
//    else -> COMPARE.
//  - FLUSH: tpg_en=0, ora_en=1, test_mode=1, busy=1. Decrement counter; exactly CUT_LATENCY cycles, then -> COMPARE.
//  - COMPARE (1 cycle): busy=1, test_mode=1, ora_en=0. Latch sig_out<=signature and
//    pass<=(signature==GOLDEN_SIG). -> DONE.
//  - DONE: done=1, pass and sig_out held, test_mode=0. Stays until start=1 (-> INIT, done/pass
//    drop on the next cycle) or abort=1 (-> IDLE).
//  - abort=1 in INIT/RUN/FLUSH/COMPARE/DONE: -> IDLE on the next edge; pass and sig_out cleared, done=0.
//    abort has priority over start in the same cycle. abort in IDLE: no effect.
//  - start is ignored while busy=1 (no restart mid-session).
//  - Session latency from start sampled in IDLE to done=1: PATTERN_COUNT + CUT_LATENCY + 3 cycles.
//  - Counter is 8 bits; it never wraps (a state exit occurs at 0).
//  - Reset asserted mid-session: immediate IDLE and all outputs 0; no partial result reported.
// TESTING
//  1. Release reset, hold start=0 for 10 cycles -> all outputs stay 0, state IDLE.
//  2. Defaults, signature driven to 3'b101 in COMPARE, 1-cycle start -> tpg_init 1 cycle,
//     tpg_en high exactly 7 cycles, done=1 at cycle 10 after start sampled, pass=1, sig_out=3'b101.
//  3. Same with signature=3'b100 -> done=1, pass=0, sig_out=3'b100; start again from DONE
//     -> INIT next cycle, done falls, a new 7-pattern run follows.
//  4. CUT_LATENCY=2 -> ora_en high 9 cycles, tpg_en high 7, done at cycle 12.
//  5. abort at 4th RUN cycle, start=1 in the same cycle -> IDLE next cycle, all outputs 0, done never asserted.
//  6. reset pulled low during FLUSH -> outputs 0 asynchronously; after release, start -> full clean session.

Source files
------------

// File: rtl/bist_controller_if.sv
// Test-port and datapath-control bundle between the BIST controller and the system/datapath side.
interface bist_controller_if #(
  parameter int unsigned SIG_WIDTH = 3
);
  logic                 start;
  logic                 abort;
  logic [SIG_WIDTH-1:0] signature;
  logic                 tpg_init;
  logic                 tpg_en;
  logic                 test_mode;
  logic                 ora_clear;
  logic                 ora_en;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [SIG_WIDTH-1:0] sig_out;

  // Controller side
  modport slave (
    input  start, abort, signature,
    output tpg_init, tpg_en, test_mode, ora_clear, ora_en, busy, done, pass, sig_out
  );

  // System / datapath side
  modport master (
    output start, abort, signature,
    input  tpg_init, tpg_en, test_mode, ora_clear, ora_en, busy, done, pass, sig_out
  );
endinterface

// File: rtl/bist_controller.sv
// BIST session sequencer: init TPG/ORA, run patterns, flush CUT latency, compare signature.
module bist_controller #(
  parameter int unsigned          PATTERN_COUNT = 7,
  parameter int unsigned          CUT_LATENCY   = 0,
  parameter int unsigned          SIG_WIDTH     = 3,
  parameter logic [SIG_WIDTH-1:0] GOLDEN_SIG    = 3'b101
) (
  input  logic              clock,
  input  logic              reset,
  bist_controller_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_FLUSH,
    S_COMPARE,
    S_DONE
  } state_t;

  localparam logic [7:0] RUN_LOAD   = 8'(PATTERN_COUNT - 1);
  localparam logic [7:0] FLUSH_LOAD = 8'(CUT_LATENCY - 1);

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pass_q, pass_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;

  // Next-state, counter and result logic; abort outranks every other transition
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    sig_d   = sig_q;
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      pass_d  = 1'b0;
      sig_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) state_d = S_INIT;
        end
        S_INIT: begin
          cnt_d   = RUN_LOAD;
          state_d = S_RUN;
        end
        S_RUN: begin
          if (cnt_q == '0) begin
            if (CUT_LATENCY > 0) begin
              cnt_d   = FLUSH_LOAD;
              state_d = S_FLUSH;
            end else begin
              state_d = S_COMPARE;
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) state_d = S_COMPARE;
          else             cnt_d   = cnt_q - 8'd1;
        end
        S_COMPARE: begin
          sig_d   = bus.signature;
          pass_d  = (bus.signature == GOLDEN_SIG);
          state_d = S_DONE;
        end
        S_DONE: begin
          if (bus.start) begin
            pass_d  = 1'b0;
            state_d = S_INIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
      sig_q   <= sig_d;
    end
  end

  // Moore output decode from the registered state
  always_comb begin
    bus.tpg_init  = (state_q == S_INIT);
    bus.ora_clear = (state_q == S_INIT);
    bus.tpg_en    = (state_q == S_RUN);
    bus.ora_en    = (state_q == S_RUN) || (state_q == S_FLUSH);
    bus.busy      = (state_q == S_INIT) || (state_q == S_RUN) ||
                    (state_q == S_FLUSH) || (state_q == S_COMPARE);
    bus.test_mode = bus.busy;
    bus.done      = (state_q == S_DONE);
    bus.pass      = pass_q;
    bus.sig_out   = sig_q;
  end

endmodule
